// File: rtl/sort_ingress_packer_pkg.sv
// Shared definitions for the ingress packer: lane field layout, idle-lane fill
// and FSM state encoding.
package sort_ingress_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATHER = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

    // Lanes that carry no cell this launch are driven with this bit in every position.
    localparam logic IDLE_FILL = 1'b0;

    localparam int unsigned DATA_LSB = 0;

    function automatic int unsigned id_w_f(input int unsigned port_nub);
        return $clog2(port_nub);
    endfunction

    function automatic int unsigned field_w_f(input int unsigned port_nub,
                                              input int unsigned data_width);
        return 2 * id_w_f(port_nub) + data_width;
    endfunction

    function automatic int unsigned dst_lsb_f(input int unsigned data_width);
        return data_width;
    endfunction

    function automatic int unsigned src_lsb_f(input int unsigned port_nub,
                                              input int unsigned data_width);
        return data_width + id_w_f(port_nub);
    endfunction

    // Bits needed for a counter that runs 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w_f(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sort_ingress_packer_lane_fifo.sv
// Per-lane synchronous FIFO with registered count and registered not-full /
// nonempty flags; push and pop may occur in the same cycle.
module sort_ingress_packer_lane_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] head_c,
    output logic         not_full,
    output logic         nonempty,
    output logic         nonempty_nxt_c
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push        = push && not_full;
    assign do_pop         = pop && nonempty;
    assign head_c         = mem[rd_ptr];
    assign nonempty_nxt_c = (cnt_nxt != '0);

    always_comb begin
        cnt_nxt = cnt;
        if (do_push && !do_pop) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            not_full <= 1'b1;
            nonempty <= 1'b0;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                mem[j] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt      <= cnt_nxt;
            not_full <= (cnt_nxt != CNT_W'(DEPTH));
            nonempty <= (cnt_nxt != '0);
        end
    end

endmodule

// File: rtl/sort_ingress_packer.sv
// Ingress packer: buffers per-port cells, stamps source ids and launches aligned
// port vectors into the sorting network under fill / timeout / spacing rules.
module sort_ingress_packer
    import sort_ingress_packer_pkg::*;
#(
    parameter  int unsigned PORT_NUB   = 16,
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned FIFO_DEPTH = 4,
    parameter  int unsigned MAX_WAIT   = 8,
    parameter  int unsigned MIN_GAP    = 1,
    localparam int unsigned ID_W       = id_w_f(PORT_NUB),
    localparam int unsigned W          = field_w_f(PORT_NUB, DATA_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PORT_NUB-1:0]          in_valid,
    output logic [PORT_NUB-1:0]          in_ready,
    input  logic [PORT_NUB*ID_W-1:0]     in_dst,
    input  logic [PORT_NUB*DATA_WIDTH-1:0] in_data,
    input  logic                         net_hold,
    output logic                         out_valid,
    output logic [PORT_NUB-1:0]          out_lane_valid,
    output logic [PORT_NUB*W-1:0]        port_out,
    output logic [15:0]                  launch_cnt
);
    localparam int unsigned SRC_LSB   = src_lsb_f(PORT_NUB, DATA_WIDTH);
    localparam int unsigned DST_LSB   = dst_lsb_f(DATA_WIDTH);
    localparam int unsigned WAIT_W    = cnt_w_f(MAX_WAIT);
    localparam int unsigned GAP_W     = cnt_w_f(MIN_GAP);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((MIN_GAP > 1) ? MIN_GAP - 2 : 0);

    logic [PORT_NUB-1:0]   nonempty;
    logic [PORT_NUB-1:0]   nonempty_nxt_c;
    logic [PORT_NUB*W-1:0] vec_c;
    logic                  launch_c;
    logic                  any_full_c;
    logic                  all_ne_c;

    state_e            state_q;
    state_e            state_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_d;

    for (genvar i = 0; i < PORT_NUB; i++) begin : g_lane
        logic [W-1:0] wdata;
        logic [W-1:0] head_c;

        assign wdata[SRC_LSB +: ID_W]        = ID_W'(i);
        assign wdata[DST_LSB +: ID_W]        = in_dst[i*ID_W +: ID_W];
        assign wdata[DATA_LSB +: DATA_WIDTH] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign vec_c[i*W +: W] = nonempty[i] ? head_c : {W{IDLE_FILL}};

        sort_ingress_packer_lane_fifo #(
            .W     (W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk            (clk),
            .rst_n          (rst_n),
            .push           (in_valid[i]),
            .pop            (launch_c),
            .wdata          (wdata),
            .head_c         (head_c),
            .not_full       (in_ready[i]),
            .nonempty       (nonempty[i]),
            .nonempty_nxt_c (nonempty_nxt_c[i])
        );
    end

    assign any_full_c = ~&in_ready;
    assign all_ne_c   = &nonempty;

    // Launch decision and post-launch spacing.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        gap_d    = gap_q;
        launch_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|nonempty) begin
                    state_d = ST_GATHER;
                    wait_d  = '0;
                end
            end
            ST_GATHER: begin
                if (!net_hold && (any_full_c || all_ne_c || (wait_q == WAIT_LAST))) begin
                    launch_c = 1'b1;
                    wait_d   = '0;
                    gap_d    = '0;
                    if (MIN_GAP > 1) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = (|nonempty_nxt_c) ? ST_GATHER : ST_IDLE;
                    end
                end else if (wait_q != WAIT_LAST) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = (|nonempty_nxt_c) ? ST_GATHER : ST_IDLE;
                    wait_d  = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            gap_q   <= gap_d;
        end
    end

    // Output vector register; holds between launches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_lane_valid <= '0;
            port_out       <= '0;
            launch_cnt     <= '0;
        end else begin
            out_valid <= launch_c;
            if (launch_c) begin
                out_lane_valid <= nonempty;
                port_out       <= vec_c;
                launch_cnt     <= launch_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sort_ingress_packer.sv
// Bench for sort_ingress_packer: two instances (MIN_GAP 1 and 4) share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_sort_ingress_packer;
    localparam int P     = 16;
    localparam int DW    = 8;
    localparam int ID_W  = 4;
    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int MW    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [P-1:0]     in_valid;
    logic [P*ID_W-1:0] in_dst;
    logic [P*DW-1:0]  in_data;
    logic             net_hold;
    logic [P-1:0]     in_ready0, in_ready1, olv0, olv1;
    logic             ov0, ov1;
    logic [P*W-1:0]   po0, po1;
    logic [15:0]      lc0, lc1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sort_ingress_packer #(.PORT_NUB(P), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
                          .MAX_WAIT(MW), .MIN_GAP(1)) u_dut_g1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_dst(in_dst), .in_data(in_data), .net_hold(net_hold),
        .out_valid(ov0), .out_lane_valid(olv0), .port_out(po0), .launch_cnt(lc0));

    sort_ingress_packer #(.PORT_NUB(P), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
                          .MAX_WAIT(MW), .MIN_GAP(4)) u_dut_g4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_dst(in_dst), .in_data(in_data), .net_hold(net_hold),
        .out_valid(ov1), .out_lane_valid(olv1), .port_out(po1), .launch_cnt(lc1));

    // Reference state, instance k lane i queue at index k*P+i.
    logic [W-1:0]   mq [2*P][$];
    bit             m_gath [2];
    int             m_age [2];
    int             m_last [2];
    bit             m_launched [2];
    logic           m_ov [2];
    logic [P-1:0]   m_lv [2];
    logic [P*W-1:0] m_po [2];
    logic [15:0]    m_lc [2];
    int             edge_n = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int gap_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    task automatic model_reset();
        for (int q = 0; q < 2*P; q++) mq[q].delete();
        for (int k = 0; k < 2; k++) begin
            m_gath[k] = 0; m_age[k] = 0; m_last[k] = 0; m_launched[k] = 0;
            m_ov[k] = 1'b0; m_lv[k] = '0; m_po[k] = '0; m_lc[k] = '0;
        end
    endtask

    // One clock edge of instance k, using the inputs held across the edge.
    task automatic model_step(input int k);
        bit any_full, all_ne, ne_before, ne_after, launch;
        logic [P-1:0] rdy;
        int sz;
        any_full = 0; all_ne = 1; ne_before = 0; ne_after = 0;
        for (int i = 0; i < P; i++) begin
            sz = mq[k*P+i].size();
            rdy[i] = (sz < DEPTH);
            if (sz == DEPTH) any_full = 1;
            if (sz == 0) all_ne = 0; else ne_before = 1;
        end
        launch = m_gath[k] && !net_hold && (any_full || all_ne || m_age[k] >= MW-1);
        m_ov[k] = launch;
        if (launch) begin
            m_lv[k] = '0;
            m_po[k] = '0;
            for (int i = 0; i < P; i++) begin
                if (mq[k*P+i].size() > 0) begin
                    m_lv[k][i] = 1'b1;
                    m_po[k][i*W +: W] = mq[k*P+i].pop_front();
                end
            end
            m_lc[k] = m_lc[k] + 16'd1;
        end
        for (int i = 0; i < P; i++)
            if (in_valid[i] && rdy[i])
                mq[k*P+i].push_back({ID_W'(i), in_dst[i*ID_W +: ID_W], in_data[i*DW +: DW]});
        for (int i = 0; i < P; i++) if (mq[k*P+i].size() > 0) ne_after = 1;
        if (launch) begin
            m_gath[k] = (gap_of(k) == 1) && ne_after;
            m_age[k] = 0; m_last[k] = edge_n; m_launched[k] = 1;
        end else if (m_gath[k]) begin
            if (m_age[k] < MW-1) m_age[k] = m_age[k] + 1;
        end else if (m_launched[k] && edge_n < m_last[k] + gap_of(k) - 1) begin
            m_gath[k] = 0;
        end else if (m_launched[k] && edge_n == m_last[k] + gap_of(k) - 1) begin
            m_gath[k] = ne_after; m_age[k] = 0;
        end else begin
            m_gath[k] = ne_before; m_age[k] = 0;
        end
    endtask

    task automatic check_all();
        logic [P-1:0] rdy0, rdy1;
        for (int i = 0; i < P; i++) begin
            rdy0[i] = (mq[i].size() < DEPTH);
            rdy1[i] = (mq[P+i].size() < DEPTH);
        end
        check("g1_in_ready",   256'(in_ready0), 256'(rdy0));
        check("g1_out_valid",  256'(ov0),       256'(m_ov[0]));
        check("g1_lane_valid", 256'(olv0),      256'(m_lv[0]));
        check("g1_port_out",   256'(po0),       256'(m_po[0]));
        check("g1_launch_cnt", 256'(lc0),       256'(m_lc[0]));
        check("g4_in_ready",   256'(in_ready1), 256'(rdy1));
        check("g4_out_valid",  256'(ov1),       256'(m_ov[1]));
        check("g4_lane_valid", 256'(olv1),      256'(m_lv[1]));
        check("g4_port_out",   256'(po1),       256'(m_po[1]));
        check("g4_launch_cnt", 256'(lc1),       256'(m_lc[1]));
    endtask

    task automatic tick(input logic [P-1:0] v, input logic [P*ID_W-1:0] d,
                        input logic [P*DW-1:0] x, input logic h);
        in_valid = v; in_dst = d; in_data = x; net_hold = h;
        @(posedge clk);
        model_step(0);
        model_step(1);
        edge_n++;
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = '0; net_hold = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [P*ID_W-1:0] rand_dst();
        logic [P*ID_W-1:0] r;
        for (int i = 0; i < P; i++) r[i*ID_W +: ID_W] = ID_W'($urandom);
        return r;
    endfunction

    function automatic logic [P*DW-1:0] rand_data();
        logic [P*DW-1:0] r;
        for (int i = 0; i < P; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    initial begin
        logic [P-1:0]      v;
        logic [P*ID_W-1:0] d;
        logic [P*DW-1:0]   x;
        logic [P*W-1:0]    exp_po;
        int                last_e;
        int                pulses;
        int                mode;

        rst_n = 1'b1; in_valid = '0; in_dst = '0; in_data = '0; net_hold = 1'b0;
        #3;
        do_reset();
        check("t1_in_ready",   256'(in_ready0), 256'(16'hFFFF));
        check("t1_out_valid",  256'(ov0),       256'(1'b0));
        check("t1_port_out",   256'(po0),       256'(0));
        check("t1_launch_cnt", 256'(lc0),       256'(0));

        // Single cell on lane 3 times out; lane 5 pushed on the launch edge waits a full window.
        d = '0; d[3*ID_W +: ID_W] = 4'd9; x = '0; x[3*DW +: DW] = 8'hA5;
        tick(16'h0008, d, x, 1'b0);
        for (int c = 1; c <= 8; c++) tick('0, '0, '0, 1'b0);
        d = '0; d[5*ID_W +: ID_W] = 4'd2; x = '0; x[5*DW +: DW] = 8'h5C;
        tick(16'h0020, d, x, 1'b0);
        exp_po = '0; exp_po[3*W +: W] = 16'h39A5;
        check("t2_out_valid",  256'(ov0),  256'(1'b1));
        check("t2_lane_valid", 256'(olv0), 256'(16'h0008));
        check("t2_port_out",   256'(po0),  256'(exp_po));
        for (int c = 0; c < 7; c++) tick('0, '0, '0, 1'b0);
        check("t5_not_yet", 256'(ov0), 256'(1'b0));
        tick('0, '0, '0, 1'b0);
        exp_po = '0; exp_po[5*W +: W] = 16'h525C;
        check("t5_out_valid",  256'(ov0),  256'(1'b1));
        check("t5_lane_valid", 256'(olv0), 256'(16'h0020));
        check("t5_port_out",   256'(po0),  256'(exp_po));

        // All lanes at once launch two cycles later.
        do_reset();
        x = rand_data();
        for (int i = 0; i < P; i++) d[i*ID_W +: ID_W] = ID_W'(15 - i);
        tick('1, d, x, 1'b0);
        tick('0, '0, '0, 1'b0);
        tick('0, '0, '0, 1'b0);
        for (int i = 0; i < P; i++) exp_po[i*W +: W] = {ID_W'(i), ID_W'(15 - i), x[i*DW +: DW]};
        check("t3_out_valid",  256'(ov0),  256'(1'b1));
        check("t3_lane_valid", 256'(olv0), 256'(16'hFFFF));
        check("t3_port_out",   256'(po0),  256'(exp_po));

        // Fill lane 0 under net_hold, then release.
        do_reset();
        for (int c = 0; c < 4; c++) tick(16'h0001, rand_dst(), rand_data(), 1'b1);
        check("t4_full_ready", 256'(in_ready0[0]), 256'(1'b0));
        check("t4_held",       256'(ov0),          256'(1'b0));
        tick('0, '0, '0, 1'b0);
        check("t4_out_valid",  256'(ov0),          256'(1'b1));
        check("t4_lane_valid", 256'(olv0),         256'(16'h0001));
        check("t4_ready_back", 256'(in_ready0[0]), 256'(1'b1));

        // Continuous traffic on the MIN_GAP=4 instance, then reset mid-stream.
        do_reset();
        last_e = -1; pulses = 0;
        for (int c = 0; c < 24; c++) begin
            tick('1, rand_dst(), rand_data(), 1'b0);
            if (ov1) begin
                if (last_e >= 0) check("t6_spacing", 256'(c - last_e), 256'(4));
                last_e = c;
                pulses++;
            end
        end
        check("t6_pulses", 256'(pulses), 256'(6));
        do_reset();
        check("t6_rst_valid", 256'(ov1),       256'(1'b0));
        check("t6_rst_ready", 256'(in_ready1), 256'(16'hFFFF));

        // Randomized traffic with holds and occasional resets.
        for (int c = 0; c < 2000; c++) begin
            mode = (c / 250) % 4;
            case (mode)
                0:       v = ($urandom_range(0, 5) == 0) ? P'(1 << $urandom_range(0, P-1)) : '0;
                1:       v = P'($urandom) & P'($urandom) & P'($urandom);
                2:       v = P'($urandom);
                default: v = P'($urandom) | P'($urandom);
            endcase
            tick(v, rand_dst(), rand_data(), ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 399) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
